// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared types and constants for the PC redirect controller
//
// Purpose: state encoding, address width and redirect-source tags used by
//          pc_redirect_ctrl and its priority selector.
package pc_redirect_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PEND       = 2'd1,
    TRAP_DRAIN = 2'd2,
    TRAP_ISSUE = 2'd3
  } redir_state_t;

  // Which request won arbitration this cycle; kept mainly for debug visibility.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_MRET = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_t;

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// rtl/pc_redirect_ctrl_prio_sel.sv - fixed-priority redirect source selector
//
// Purpose: picks the single winning redirect request (trap > mret > branch)
//          and its target. Purely combinational.
// Ports:
//   trap_req/trap_vector  trap entry request and handler address
//   mret_req/mepc         mret request and return address
//   br_taken/br_target    taken branch/jump and destination
//   src                   winning source (SRC_NONE when nothing requested)
//   target                target of the winner (0 when nothing requested)
module redirect_prio_sel
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN = pc_redirect_ctrl_pkg::XLEN
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output redir_src_t      src,
  output logic [XLEN-1:0] target
);

  always_comb begin
    src    = SRC_NONE;
    target = '0;
    if (trap_req) begin
      src    = SRC_TRAP;
      target = trap_vector;
    end else if (mret_req) begin
      src    = SRC_MRET;
      target = mepc;
    end else if (br_taken) begin
      src    = SRC_BR;
      target = br_target;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - program counter redirect sequencer and stall merger
//
// Purpose: sole driver of the pc module's j_signal/jump/stall. Arbitrates
//          trap/mret/branch redirects, holds a redirect until fetch is ready,
//          and drains outstanding stores (with timeout) before trap entry.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   br_taken, br_target       taken branch/jump from EX
//   mret_req, mepc            mret retirement and return address
//   trap_req, trap_vector     trap entry request (held until trap_ack)
//   hazard_stall              load-use stall
//   fetch_ready               instruction memory accepts a new PC
//   drain_done                no stores outstanding in MEM/WB
//   j_signal, jump            redirect pulse and word-aligned target
//   pc_stall                  merged PC hold (combinational)
//   flush_if_id, flush_id_ex  pipeline kill pulses
//   trap_ack                  one-cycle pulse with the trap redirect
//   busy                      controller not idle
//   drain_err                 sticky drain-timeout flag
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN          = pc_redirect_ctrl_pkg::XLEN,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            hazard_stall,
  input  logic            fetch_ready,
  input  logic            drain_done,
  output logic            j_signal,
  output logic [XLEN-1:0] jump,
  output logic            pc_stall,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            trap_ack,
  output logic            busy,
  output logic            drain_err
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  redir_state_t    state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            j_d, flush_d, ack_d, err_d;
  logic [XLEN-1:0] jump_d;

  redir_src_t      sel_src;
  logic [XLEN-1:0] sel_target;

  redirect_prio_sel #(.XLEN(XLEN)) u_prio_sel (
    .trap_req    (trap_req),
    .trap_vector (trap_vector),
    .mret_req    (mret_req),
    .mepc        (mepc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .src         (sel_src),
    .target      (sel_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      cnt_q       <= '0;
      j_signal    <= 1'b0;
      jump        <= '0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      trap_ack    <= 1'b0;
      drain_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      j_signal    <= j_d;
      jump        <= jump_d;
      flush_if_id <= flush_d;
      flush_id_ex <= flush_d;
      trap_ack    <= ack_d;
      drain_err   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    err_d    = drain_err;
    j_d      = 1'b0;
    jump_d   = '0;
    flush_d  = 1'b0;
    ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_src == SRC_TRAP) begin
          // Kill the wrong-path instructions now; the jump waits for the drain.
          target_d = sel_target;
          cnt_d    = '0;
          flush_d  = 1'b1;
          state_d  = TRAP_DRAIN;
        end else if (sel_src != SRC_NONE) begin
          if (fetch_ready) begin
            j_d     = 1'b1;
            jump_d  = {sel_target[XLEN-1:2], 2'b00};
            flush_d = 1'b1;
          end else begin
            target_d = sel_target;
            state_d  = PEND;
          end
        end
      end

      PEND: begin
        if (sel_src == SRC_TRAP) begin
          target_d = sel_target;
          cnt_d    = '0;
          state_d  = TRAP_DRAIN;
        end else if (fetch_ready) begin
          j_d     = 1'b1;
          jump_d  = {target_q[XLEN-1:2], 2'b00};
          flush_d = 1'b1;
          state_d = IDLE;
        end
      end

      TRAP_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (drain_done) begin
          state_d = TRAP_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up waiting; the trap is taken anyway and the event is recorded.
          err_d   = 1'b1;
          state_d = TRAP_ISSUE;
        end
      end

      TRAP_ISSUE: begin
        if (fetch_ready) begin
          j_d     = 1'b1;
          jump_d  = {target_q[XLEN-1:2], 2'b00};
          flush_d = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  // A redirect cycle must let the PC load, so j_signal overrides every stall.
  assign pc_stall = (hazard_stall | ~fetch_ready | busy) & ~j_signal;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - randomized self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            br_taken = 1'b0;
  logic [XLEN-1:0] br_target = '0;
  logic            mret_req = 1'b0;
  logic [XLEN-1:0] mepc = '0;
  logic            trap_req = 1'b0;
  logic [XLEN-1:0] trap_vector = '0;
  logic            hazard_stall = 1'b0;
  logic            fetch_ready = 1'b1;
  logic            drain_done = 1'b0;
  logic            j_signal;
  logic [XLEN-1:0] jump;
  logic            pc_stall;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            trap_ack;
  logic            busy;
  logic            drain_err;

  pc_redirect_ctrl #(.XLEN(XLEN), .DRAIN_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .mret_req     (mret_req),
    .mepc         (mepc),
    .trap_req     (trap_req),
    .trap_vector  (trap_vector),
    .hazard_stall (hazard_stall),
    .fetch_ready  (fetch_ready),
    .drain_done   (drain_done),
    .j_signal     (j_signal),
    .jump         (jump),
    .pc_stall     (pc_stall),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .trap_ack     (trap_ack),
    .busy         (busy),
    .drain_err    (drain_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks what the controller is waiting for, not how it encodes it.
  bit              m_waiting_fetch;   // redirect held for fetch_ready
  bit              m_draining;        // waiting for stores before trap entry
  bit              m_trap_ready;      // drain over, trap jump waiting for fetch_ready
  int              m_drain_cycles;
  logic [XLEN-1:0] m_target;
  bit              m_err;
  bit              e_j, e_flush, e_ack;
  logic [XLEN-1:0] e_jump;

  function automatic bit m_busy();
    return m_waiting_fetch || m_draining || m_trap_ready;
  endfunction

  task automatic model_reset();
    m_waiting_fetch = 0; m_draining = 0; m_trap_ready = 0;
    m_drain_cycles = 0; m_target = '0; m_err = 0;
    e_j = 0; e_flush = 0; e_ack = 0; e_jump = '0;
  endtask

  task automatic model_step();
    bit nj, nfl, nack;
    logic [XLEN-1:0] njump;
    nj = 0; nfl = 0; nack = 0; njump = '0;
    if (m_draining) begin
      if (drain_done) begin
        m_draining = 0; m_trap_ready = 1;
      end else if (m_drain_cycles == TIMEOUT - 1) begin
        m_err = 1; m_draining = 0; m_trap_ready = 1;
      end else begin
        m_drain_cycles++;
      end
    end else if (m_trap_ready) begin
      if (fetch_ready) begin
        nj = 1; nfl = 1; nack = 1; njump = m_target & ~32'h3;
        m_trap_ready = 0;
      end
    end else if (m_waiting_fetch) begin
      if (trap_req) begin
        m_target = trap_vector; m_waiting_fetch = 0; m_draining = 1; m_drain_cycles = 0;
      end else if (fetch_ready) begin
        nj = 1; nfl = 1; njump = m_target & ~32'h3;
        m_waiting_fetch = 0;
      end
    end else begin
      if (trap_req) begin
        m_target = trap_vector; m_draining = 1; m_drain_cycles = 0; nfl = 1;
      end else if (mret_req || br_taken) begin
        logic [XLEN-1:0] t;
        t = mret_req ? mepc : br_target;
        if (fetch_ready) begin
          nj = 1; nfl = 1; njump = t & ~32'h3;
        end else begin
          m_target = t; m_waiting_fetch = 1;
        end
      end
    end
    e_j = nj; e_flush = nfl; e_ack = nack; e_jump = njump;
  endtask

  task automatic compare_all();
    bit exp_stall;
    exp_stall = (hazard_stall || !fetch_ready || m_busy()) && !e_j;
    check("j_signal",    32'(j_signal),    32'(e_j));
    check("jump",        jump,             e_jump);
    check("flush_if_id", 32'(flush_if_id), 32'(e_flush));
    check("flush_id_ex", 32'(flush_id_ex), 32'(e_flush));
    check("trap_ack",    32'(trap_ack),    32'(e_ack));
    check("busy",        32'(busy),        32'(m_busy()));
    check("drain_err",   32'(drain_err),   32'(m_err));
    check("pc_stall",    32'(pc_stall),    32'(exp_stall));
  endtask

  // One clock: model advances on the same edge as the DUT, outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    br_taken = 0; mret_req = 0; trap_req = 0; hazard_stall = 0;
    fetch_ready = 1; drain_done = 0;
  endtask

  initial begin
    int waited;
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_j",     32'(j_signal),  32'h0);
    check("reset_busy",  32'(busy),      32'h0);
    check("reset_err",   32'(drain_err), 32'h0);
    check("reset_jump",  jump,           32'h0);
    @(negedge clk);
    rst = 1;

    // Branch with fetch ready: one-cycle aligned pulse.
    br_taken = 1; br_target = 32'h0000_0102;
    tick();
    br_taken = 0;
    check("br_jump_aligned", jump, 32'h0000_0100);
    check("br_j", 32'(j_signal), 32'h1);
    tick();
    check("br_pulse_end", 32'(j_signal), 32'h0);

    // Branch while fetch not ready: held in PEND.
    br_taken = 1; br_target = 32'h200; fetch_ready = 0;
    tick();
    br_taken = 0;
    tick(); tick();
    check("pend_stall", 32'(pc_stall), 32'h1);
    check("pend_busy",  32'(busy),     32'h1);
    fetch_ready = 1;
    tick();
    check("pend_jump", jump, 32'h200);
    tick();

    // Simultaneous trap/mret/branch: trap wins, drain completes after 4 cycles.
    trap_req = 1; trap_vector = 32'h80; mret_req = 1; mepc = 32'h444; br_taken = 1; br_target = 32'h888;
    tick();
    mret_req = 0; br_taken = 0;
    check("trap_flush_noj", 32'(j_signal), 32'h0);
    repeat (3) tick();
    drain_done = 1;
    tick();
    drain_done = 0;
    tick();
    check("trap_jump", jump, 32'h80);
    check("trap_ack_pulse", 32'(trap_ack), 32'h1);
    trap_req = 0;
    tick();

    // Drain timeout: drain_done never comes.
    trap_req = 1; trap_vector = 32'h0000_0C00;
    waited = 0;
    tick();
    while (!j_signal && waited < 40) begin
      tick();
      waited++;
    end
    check("timeout_bound", 32'(j_signal), 32'h1);
    check("timeout_err",   32'(drain_err), 32'h1);
    check("timeout_jump",  jump, 32'h0000_0C00);
    trap_req = 0;
    repeat (3) tick();
    check("err_sticky", 32'(drain_err), 32'h1);

    // Asynchronous reset mid-drain.
    trap_req = 1; trap_vector = 32'h0000_1000;
    tick(); tick();
    #2;
    rst = 0;
    #1;
    model_reset();
    check("arst_busy", 32'(busy),        32'h0);
    check("arst_err",  32'(drain_err),   32'h0);
    check("arst_fl",   32'(flush_if_id), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    repeat (3) tick();
    check("arst_nojump", 32'(j_signal), 32'h0);

    // Hazard stall alone, then a branch during the stall.
    hazard_stall = 1;
    tick();
    check("hz_stall", 32'(pc_stall), 32'h1);
    br_taken = 1; br_target = 32'h0000_0344;
    tick();
    br_taken = 0;
    check("hz_br_jump", jump, 32'h0000_0344);
    hazard_stall = 0;
    tick();

    // Randomized traffic; trap_req follows the hold-until-ack protocol, sometimes dropped early.
    for (int i = 0; i < 3000; i++) begin
      br_taken     = ($urandom_range(3) == 0);
      br_target    = $urandom;
      mret_req     = ($urandom_range(7) == 0);
      mepc         = $urandom;
      hazard_stall = ($urandom_range(3) == 0);
      fetch_ready  = ($urandom_range(3) != 0);
      drain_done   = ($urandom_range(5) == 0);
      if (!trap_req && $urandom_range(19) == 0) begin
        trap_req = 1; trap_vector = $urandom;
      end else if (trap_req && $urandom_range(47) == 0) begin
        trap_req = 0;
      end
      tick();
      if (trap_ack) trap_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences the program counter: the single owner of the pc module's j_signal/jump/stall inputs.
- Arbitrates among redirect sources in priority order:
  - trap entry from the CSR unit;
  - mret return;
  - taken branch/jump from EX.
- Merges pipeline stall sources into the PC stall.
- Holds a redirect while instruction fetch is not ready.
- Drains outstanding memory traffic before trap entry.
- Sits between the EX/CSR stages, the hazard unit, instruction memory and the pc module.

Parameters:
- XLEN, 32, address/target width.
- DRAIN_TIMEOUT, 16, maximum cycles spent waiting for drain_done before trap entry proceeds anyway (>=2).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- br_taken  in  1  EX resolved a taken branch/jump this cycle.
- br_target  in  XLEN  branch/jump destination.
- mret_req  in  1  mret retiring this cycle.
- mepc  in  XLEN  return address for mret.
- trap_req  in  1  CSR unit requests trap entry; held until trap_ack.
- trap_vector  in  XLEN  trap handler address.
- hazard_stall  in  1  load-use stall from hazard unit.
- fetch_ready  in  1  instruction memory can accept a new PC.
- drain_done  in  1  no outstanding stores in MEM/WB.
- j_signal  out  1  load jump into PC (to pc module).
- jump  out  XLEN  redirect target (to pc module).
- pc_stall  out  1  hold PC (to pc module stall).
- flush_if_id  out  1  kill IF/ID register contents.
- flush_id_ex  out  1  kill ID/EX register contents.
- trap_ack  out  1  one-cycle pulse: trap redirect issued.
- busy  out  1  controller not in IDLE.
- drain_err  out  1  sticky: a drain timed out.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State goes to IDLE.
  - Registered outputs j_signal, jump, flush_if_id, flush_id_ex, trap_ack and drain_err are 0.
  - Pending target and drain counter are cleared.
- State machine: IDLE, PEND, TRAP_DRAIN, TRAP_ISSUE. busy=1 in every state except IDLE.
- Redirect pulse, issued at edge N:
  - During cycle N+1: j_signal=1, jump=target with bits [1:0] forced to 0, flush_if_id=1, flush_id_ex=1.
  - The pc module loads the target at edge N+2.
  - Pulses last exactly one cycle unless a new redirect is issued at edge N+1 (back-to-back redirects are allowed).
- pc_stall is combinational: (hazard_stall | ~fetch_ready | state==PEND | state==TRAP_DRAIN | state==TRAP_ISSUE) & ~j_signal.
- Priority at a single edge: trap_req > mret_req > br_taken. Losers are dropped, not queued; they are wrong-path and get flushed.
- IDLE:
  - trap_req: latch trap_vector, go to TRAP_DRAIN, clear the counter, issue a flush pulse with no j_signal.
  - Else mret_req or br_taken with fetch_ready=1: issue a redirect pulse and stay in IDLE.
  - Else mret_req or br_taken with fetch_ready=0: latch the target and go to PEND.
- PEND:
  - trap_req: overwrite the latched target with trap_vector and go to TRAP_DRAIN.
  - Else fetch_ready=1: issue the pending redirect and go to IDLE.
  - br_taken and mret_req are ignored in this state.
- TRAP_DRAIN:
  - Counter increments each cycle.
  - drain_done=1: go to TRAP_ISSUE.
  - Else counter==DRAIN_TIMEOUT-1: set drain_err and go to TRAP_ISSUE.
  - br_taken and mret_req are ignored.
- TRAP_ISSUE:
  - fetch_ready=1: issue the redirect pulse to the latched vector, assert trap_ack in the same cycle as j_signal, go to IDLE.
  - If trap_req drops early, entry still completes.
- hazard_stall never blocks redirects; it only affects pc_stall.
- drain_err clears only on reset.

Decomposition:
- Shared core package holds:
  - the state enum (2-bit encoding IDLE=0, PEND=1, TRAP_DRAIN=2, TRAP_ISSUE=3);
  - the XLEN constant;
  - a redirect-source enum {SRC_NONE, SRC_BR, SRC_MRET, SRC_TRAP} for debug.
- Natural sub-module: redirect_prio_sel, the combinational fixed-priority selector returning the winning source and target.

Test Plan:
- br_taken=1, br_target=0x0000_0102, fetch_ready=1 at edge N -> cycle N+1: j_signal=1, jump=0x0000_0100, both flushes=1; cycle N+2: all 0, busy=0.
- br_taken with target 0x200 while fetch_ready=0 for 3 cycles -> PEND, pc_stall=1, busy=1; fetch_ready rises -> next cycle j_signal=1, jump=0x200, back to IDLE.
- trap_req, mret_req and br_taken all at the same edge, trap_vector=0x80 -> flush pulse, TRAP_DRAIN; drain_done after 4 cycles -> j_signal=1, jump=0x80, trap_ack=1; mret and branch never redirect.
- trap_req with drain_done held 0 -> after 16 cycles in TRAP_DRAIN: drain_err=1, redirect to trap_vector; drain_err stays 1 until rst=0.
- rst driven low asynchronously mid-TRAP_DRAIN -> all outputs 0 immediately; after release: busy=0 and no pending redirect issued.
- hazard_stall=1 in IDLE with no redirect -> pc_stall=1, j_signal=0; a branch during the stall still redirects next cycle.
